// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Imported by rr_pick and bus_arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic M0       = 1'b0;
    localparam logic M1       = 1'b1;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Index of the master that is not idx (two-master case).
    function automatic logic other_master(input logic idx);
        return (idx == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selection between two requesters.
// A tie goes to the master that was not granted last.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic idx
);

    // Pick a winner from the current request vector.
    always_comb begin
        valid = req0 | req1;
        idx   = M0;
        if (req0 && req1) begin
            idx = other_master(last_grant);
        end else if (req1) begin
            idx = M1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter with round-robin grant,
// registered slave outputs and a per-transaction timeout.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic            m0_rw,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_be,
    output logic            m0_ready,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_err,
    input  logic            m1_req,
    input  logic            m1_rw,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_be,
    output logic            m1_ready,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_err,
    output logic            s_req,
    output logic            s_rw,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_be,
    output logic            s_we,
    input  logic            s_ready,
    input  logic [DW-1:0]   s_rdata
);

    localparam int BW = DW / 8;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic [7:0]      timer_q, timer_d;
    logic            rw_q, rw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rdy0_q, rdy0_d;
    logic            rdy1_q, rdy1_d;
    logic            err0_q, err0_d;
    logic            err1_q, err1_d;

    logic            pick_valid;
    logic            pick_idx;

    rr_pick u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (last_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    // Next-state, latching and completion logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        timer_d = timer_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    timer_d = 8'd0;
                    state_d = BUSY;
                    if (pick_idx == M1) begin
                        rw_d    = m1_rw;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        be_d    = m1_be;
                    end else begin
                        rw_d    = m0_rw;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        be_d    = m0_be;
                    end
                end
            end
            BUSY: begin
                timer_d = timer_q + 8'd1;
                if (s_ready) begin
                    rdata_d = (rw_q == RW_READ) ? s_rdata : '0;
                    rdy0_d  = (grant_q == M0);
                    rdy1_d  = (grant_q == M1);
                    state_d = RESP;
                end else if (timer_q == TO_LAST) begin
                    rdata_d = '0;
                    rdy0_d  = (grant_q == M0);
                    rdy1_d  = (grant_q == M1);
                    err0_d  = (grant_q == M0);
                    err1_d  = (grant_q == M1);
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= M0;
            last_q  <= M1;
            timer_q <= 8'd0;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    assign s_req    = (state_q == BUSY);
    assign s_rw     = rw_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_be     = be_q;
    assign s_we     = s_req & ~rw_q;

    assign m0_ready = rdy0_q;
    assign m0_err   = err0_q;
    assign m0_rdata = rdy0_q ? rdata_q : '0;
    assign m1_ready = rdy1_q;
    assign m1_err   = err1_q;
    assign m1_rdata = rdy1_q ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (TIMEOUT = 8).
// Directed table, hand sequences, then randomized rounds.
module tb_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_rw, m1_rw;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_rw, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int checks = 0;
    int errors = 0;

    // stimulus / expectation for the current transaction
    int          lat;
    logic [31:0] rd;
    logic        perturb;
    int          exp_who, exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    int          last_w;

    typedef struct {
        logic        r0, r1, rw0, rw1;
        int          lat;
        logic [31:0] rd;
        logic        pert;
        int          ew, ec;
        logic        ee;
        logic [31:0] erd;
    } vec_t;

    vec_t vt[10];

    bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_rw(s_rw), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_be(s_be), .s_we(s_we),
        .s_ready(s_ready), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Snapshot what the slave should see from the expected winner.
    task automatic set_exp_bus();
        if (exp_who == 1) begin
            exp_addr = m1_addr; exp_wdata = m1_wdata;
            exp_be = m1_be; exp_we = ~m1_rw;
        end else begin
            exp_addr = m0_addr; exp_wdata = m0_wdata;
            exp_be = m0_be; exp_we = ~m0_rw;
        end
    endtask

    // Run one grant-to-ready round, acting as the slave.
    task automatic serve();
        int busy = 0;
        int who = -1;
        int cyc = 0;
        logic stable = 1'b1;
        logic [31:0] rdw = 0, rdo = 0;
        logic e = 0, o_rdy = 0, o_err = 0;
        for (int c = 0; c < 40 && who < 0; c++) begin
            @(posedge clk); #1;
            cyc++;
            s_ready = 1'b0;
            if (m0_ready || m1_ready) begin
                who = (m0_ready && m1_ready) ? 2 : (m1_ready ? 1 : 0);
                rdw = (who == 1) ? m1_rdata : m0_rdata;
                rdo = (who == 1) ? m0_rdata : m1_rdata;
                e = (who == 1) ? m1_err : m0_err;
                o_rdy = (who == 1) ? m0_ready : m1_ready;
                o_err = (who == 1) ? m0_err : m1_err;
            end else if (s_req) begin
                busy++;
                if (s_addr !== exp_addr || s_we !== exp_we ||
                    s_be !== exp_be || s_wdata !== exp_wdata)
                    stable = 1'b0;
                if (busy == 2 && perturb) begin
                    m0_addr = ~m0_addr; m1_addr = ~m1_addr;
                    m0_be = ~m0_be; m1_be = ~m1_be;
                    m1_wdata = ~m1_wdata; m1_rw = ~m1_rw;
                end
                if (busy == lat) begin
                    s_ready = 1'b1; s_rdata = rd;
                end else begin
                    s_rdata = $urandom;
                end
            end
        end
        chk("winner", 32'(who), 32'(exp_who));
        chk("latency", 32'(cyc), 32'(exp_cyc));
        chk("err", {31'd0, e}, {31'd0, exp_err});
        chk("rdata", rdw, exp_rdata);
        chk("other_rdata", rdo, 32'd0);
        chk("other_flags", {30'd0, o_rdy, o_err}, 32'd0);
        chk("bus_stable", {31'd0, stable}, 32'd1);
        if (who == 0 || who == 2 || who < 0) m0_req = 1'b0;
        if (who == 1 || who == 2 || who < 0) m1_req = 1'b0;
        @(posedge clk); #1;
        chk("pulse_len", {27'd0, m0_ready, m1_ready, m0_err, m1_err, s_req},
            32'd0);
    endtask

    task automatic apply_row(input vec_t v);
        m0_req = v.r0; m1_req = v.r1;
        m0_rw = v.rw0; m1_rw = v.rw1;
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_2000;
        m0_wdata = 32'hA5A5_A5A5; m1_wdata = 32'h1234_5678;
        m0_be = 4'b1111; m1_be = 4'b0011;
        lat = v.lat; rd = v.rd; perturb = v.pert;
        exp_who = v.ew; exp_cyc = v.ec;
        exp_err = v.ee; exp_rdata = v.erd;
        set_exp_bus();
        serve();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        logic        pend[2];
        logic        p_rw[2];
        logic [31:0] p_addr[2], p_wd[2];
        logic [3:0]  p_be[2];
        int          w;

        vt[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 32'h1111_1111, 1'b0,
                  0, 2, 1'b0, 32'h1111_1111};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 32'h2222_2222, 1'b0,
                  1, 3, 1'b0, 32'h2222_2222};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 3, 32'h3333_3333, 1'b0,
                  0, 4, 1'b0, 32'h3333_3333};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 32'h4444_4444, 1'b0,
                  1, 3, 1'b0, 32'h0};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 4, 32'hDEAD_BEEF, 1'b0,
                  0, 5, 1'b0, 32'hDEAD_BEEF};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 32'hCAFE_F00D, 1'b1,
                  1, 4, 1'b0, 32'h0};
        vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h5555_5555, 1'b0,
                  0, TO + 1, 1'b1, 32'h0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 1'b1, TO, 32'h6666_6666, 1'b0,
                  0, TO + 1, 1'b0, 32'h6666_6666};
        vt[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 32'h7777_7777, 1'b0,
                  1, TO + 1, 1'b1, 32'h0};
        vt[9] = '{1'b0, 1'b1, 1'b1, 1'b0, TO + 1, 32'h8888_8888, 1'b0,
                  1, TO + 1, 1'b1, 32'h0};

        reset = 1'b1;
        m0_req = 0; m1_req = 0; m0_rw = 0; m1_rw = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_be = 0; m1_be = 0; s_ready = 0; s_rdata = 0;
        perturb = 0; lat = 0; rd = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_err", {28'd0, m0_ready, m1_ready, m0_err, m1_err},
            32'd0);
        chk("rst_sreq_swe", {30'd0, s_req, s_we}, 32'd0);
        chk("rst_s_rw", {31'd0, s_rw}, 32'd1);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_s_be", {28'd0, s_be}, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        reset = 1'b0;

        foreach (vt[i]) apply_row(vt[i]);

        // stray s_ready while idle
        bad = 1'b0;
        s_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (m0_ready || m1_ready || s_req) bad = 1'b1;
        end
        s_ready = 1'b0;
        @(posedge clk); #1;
        if (m0_ready || m1_ready || s_req) bad = 1'b1;
        chk("stray_s_ready", {31'd0, bad}, 32'd0);

        // m0 completes so that m1 would win the next tie
        apply_row('{1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h9999_0000, 1'b0,
                    0, 2, 1'b0, 32'h9999_0000});

        // abort an m1 transaction with reset
        m1_req = 1'b1; m1_rw = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, s_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_sreq", {29'd0, s_req, m0_ready, m1_ready}, 32'd0);
        reset = 1'b0; m1_req = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (m0_ready || m1_ready || s_req) bad = 1'b1;
        end
        chk("abort_no_ready", {31'd0, bad}, 32'd0);
        apply_row('{1'b1, 1'b1, 1'b1, 1'b1, 2, 32'hABCD_0001, 1'b0,
                    0, 3, 1'b0, 32'hABCD_0001});
        last_w = 0;

        // randomized rounds against the arbitration model
        pend[0] = 0; pend[1] = 0;
        perturb = 1'b0;
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    p_rw[i] = 1'($urandom_range(0, 1));
                    p_addr[i] = $urandom; p_wd[i] = $urandom;
                    p_be[i] = 4'($urandom_range(0, 15));
                end
            end
            if (!pend[0] && !pend[1]) begin
                w = $urandom_range(0, 1);
                pend[w] = 1'b1; p_rw[w] = 1'b1;
                p_addr[w] = $urandom; p_wd[w] = $urandom; p_be[w] = 4'hF;
            end
            m0_req = pend[0]; m0_rw = p_rw[0]; m0_addr = p_addr[0];
            m0_wdata = p_wd[0]; m0_be = p_be[0];
            m1_req = pend[1]; m1_rw = p_rw[1]; m1_addr = p_addr[1];
            m1_wdata = p_wd[1]; m1_be = p_be[1];
            if (pend[0] && pend[1]) w = 1 - last_w;
            else w = pend[0] ? 0 : 1;
            lat = $urandom_range(0, TO + 2);
            rd = $urandom;
            exp_who = w;
            if (lat >= 1 && lat <= TO) begin
                exp_cyc = lat + 1; exp_err = 1'b0;
                exp_rdata = p_rw[w] ? rd : 32'd0;
            end else begin
                exp_cyc = TO + 1; exp_err = 1'b1; exp_rdata = 32'd0;
            end
            set_exp_bus();
            serve();
            pend[w] = 1'b0;
            last_w = w;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the processor's shared memory bus. It sits between the processor's Req/PrRw/Ready port (master 0), a second bus master such as a DMA engine (master 1), and the single memory/peripheral slave. Requests are granted round-robin and registered onto the slave. A timeout counter guarantees every granted transaction terminates, with an error flag if the slave never answers.

## Interface
- AW, 32, address width
- DW, 32, data width; BE width is DW/8
- TIMEOUT, 255, maximum wait for s_ready in cycles, 1..255; the counter is 8 bits
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  master request; held high until that master's ready pulse
- m0_rw, m1_rw  in  1  1 = read, 0 = write (PrRw encoding)
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  write data
- m0_be, m1_be  in  DW/8  byte enables
- m0_ready, m1_ready  out  1  one-cycle completion pulse to that master
- m0_rdata, m1_rdata  out  DW  read data; valid while the matching ready is high
- m0_err, m1_err  out  1  high with ready when the transaction timed out
- s_req  out  1  slave request
- s_rw  out  1  slave direction, PrRw encoding
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_be  out  DW/8  slave byte enables
- s_we  out  1  equals s_req & ~s_rw
- s_ready  in  1  slave completion; read data valid in the same cycle
- s_rdata  in  DW  slave read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the master not granted last.
  - On grant: latch that master's rw/addr/wdata/be into output registers, record grant index, clear timer, go to BUSY.
- BUSY
  - s_req = 1. Slave outputs come from the latched registers; master-side changes are ignored.
  - Timer increments each cycle.
  - If s_ready: capture s_rdata, err = 0, go to RESP.
  - Else if timer == TIMEOUT-1: rdata = 0, err = 1, go to RESP.
  - s_ready in the same cycle as the timeout wins (normal completion).
- RESP
  - Pulse ready (and err if set) to the granted master only. rdata is driven to that master only; the other master's rdata = 0.
  - Update last_grant. Go to IDLE.
- Writes return rdata = 0.
- Masters must deassert req on the edge after seeing ready. A req seen in IDLE is treated as a new request.
- s_ready outside BUSY is ignored.
- Reset values:
  - State IDLE; last_grant = 1, so master 0 wins the first tie.
  - All ready/err outputs 0; s_req 0, s_we 0.
  - s_addr/s_wdata/s_be/rdata 0; s_rw 1; timer 0.
- Reset asserted mid-transaction aborts it: no ready pulse is issued and s_req drops on the next cycle.

## Timing
- Request sampled at edge N (IDLE) -> s_req high from cycle N+1.
- s_ready at cycle N+k (k ≥ 1) -> master ready pulse at cycle N+k+1. Minimum request-to-ready latency is 2 cycles.
- Timeout: ready/err pulse occurs TIMEOUT+1 cycles after the grant edge.
- One transaction in flight. Back-to-back grants are separated by one IDLE cycle, giving full-throughput period 3 + slave wait.
- The ready and err outputs are registered.
- s_req is a pure state decode (state == BUSY).

## Structure
- Package bus_arb_pkg:
  - state enum {IDLE, BUSY, RESP}
  - master index constants M0 = 0, M1 = 1
  - RW_READ = 1, RW_WRITE = 0
- Sub-module rr_pick: combinational round-robin pick of (req0, req1, last_grant) -> (valid, idx). Kept separate so it generalises to more masters.
- Everything else lives in bus_arbiter. Expected size is about 150–250 lines.

## Test plan
- Single read: m0 read addr 0x100; slave answers 3 cycles after s_req with 0xDEADBEEF -> m0_ready for one cycle with m0_rdata = 0xDEADBEEF, m0_err = 0, m1_ready stays 0.
- Tie and alternation: m0 and m1 request together immediately after reset -> m0 is served first, then m1. Repeated ties alternate m1, m0, m1.
- Write path and request stability: m1 writes 0x12345678 with be = 4'b0011 to 0x2000. Change m1_addr while BUSY -> s_addr stays 0x2000, s_we = 1, s_be = 4'b0011, m1_rdata = 0.
- Timeout: TIMEOUT = 8 and s_ready held low -> m0_ready and m0_err pulse exactly 9 cycles after the grant edge, with rdata = 0. s_ready arriving in the timer's last BUSY cycle -> err = 0.
- Reset mid-transaction: assert reset during BUSY -> s_req = 0 on the next cycle, no ready pulse, and the following tie goes to m0.
- Stray s_ready while IDLE -> no ready pulse and no state change.
